// File: rtl/request_slot_queue.sv
// Slot-addressed request store. Pushes take a free slot from an internal free-ID FIFO.
// Pops read a slot by ID and return that ID to the FIFO tail.
module request_slot_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int LSIZE      = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push_en_in,
  input  logic [DATA_WIDTH-1:0] push_data_in,
  output logic [LSIZE-1:0]      push_slot_id_out,
  output logic                  push_done_out,
  input  logic                  pop_en_in,
  input  logic [LSIZE-1:0]      pop_slot_id_in,
  output logic [DATA_WIDTH-1:0] pop_data_out,
  input  logic                  initialize,
  output logic                  initialized,
  output logic                  error
);

  localparam int N  = 1 << LSIZE;
  localparam int CW = LSIZE + 1;

  typedef enum logic [1:0] {IDLE, INIT, READY} state_t;

  state_t                state_q, state_d;
  logic [LSIZE-1:0]      init_cnt_q;
  logic [LSIZE-1:0]      head_q, tail_q;
  logic [CW-1:0]         count_q;
  logic [N-1:0]          alloc_q;
  logic [DATA_WIDTH-1:0] mem [N];
  logic [LSIZE-1:0]      free_ids [N];

  logic             init_wr, push_ok, push_fail, pop_ok, pop_fail, pop_rd, illegal;
  logic [LSIZE-1:0] push_id;

  assign push_id     = free_ids[head_q];
  assign initialized = (state_q == READY);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A new initialize overrides everything else in the cycle it is sampled.
  always_comb begin
    state_d   = state_q;
    init_wr   = 1'b0;
    push_ok   = 1'b0;
    push_fail = 1'b0;
    pop_ok    = 1'b0;
    pop_fail  = 1'b0;
    pop_rd    = 1'b0;
    illegal   = 1'b0;
    if (initialize) begin
      state_d = INIT;
    end else begin
      case (state_q)
        INIT: begin
          init_wr = 1'b1;
          illegal = push_en_in | pop_en_in;
          if (init_cnt_q == LSIZE'(N - 1)) state_d = READY;
        end
        READY: begin
          push_ok   = push_en_in && (count_q != '0);
          push_fail = push_en_in && (count_q == '0);
          pop_rd    = pop_en_in;
          pop_ok    = pop_en_in && alloc_q[pop_slot_id_in];
          pop_fail  = pop_en_in && !alloc_q[pop_slot_id_in];
        end
        default: illegal = push_en_in | pop_en_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_cnt_q       <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      alloc_q          <= '0;
      error            <= 1'b0;
      push_done_out    <= 1'b0;
      push_slot_id_out <= '0;
      pop_data_out     <= '0;
    end else begin
      push_done_out <= push_ok;
      if (initialize) begin
        init_cnt_q <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        alloc_q    <= '0;
        error      <= 1'b0;
      end else begin
        if (init_wr) init_cnt_q <= init_cnt_q + 1'b1;
        if (init_wr || pop_ok) tail_q <= tail_q + 1'b1;
        if (push_ok) begin
          head_q           <= head_q + 1'b1;
          push_slot_id_out <= push_id;
          alloc_q[push_id] <= 1'b1;
        end
        // Push only takes free IDs, so it never collides with the slot a pop releases.
        if (pop_ok) alloc_q[pop_slot_id_in] <= 1'b0;
        count_q <= count_q + CW'(init_wr | pop_ok) - CW'(push_ok);
        if (pop_rd) pop_data_out <= mem[pop_slot_id_in];
        if (push_fail || pop_fail || illegal) error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[push_id] <= push_data_in;
    if (init_wr)     free_ids[tail_q] <= init_cnt_q;
    else if (pop_ok) free_ids[tail_q] <= pop_slot_id_in;
  end

endmodule

// File: tb/tb_request_slot_queue.sv
// Directed bench for request_slot_queue with a queue-based reference model
// and a per-cycle compare process, plus literal expectations per scenario.
module tb_request_slot_queue;

  localparam int DW = 16;
  localparam int LS = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          push_en_in;
  logic [DW-1:0] push_data_in;
  logic [LS-1:0] push_slot_id_out;
  logic          push_done_out;
  logic          pop_en_in;
  logic [LS-1:0] pop_slot_id_in;
  logic [DW-1:0] pop_data_out;
  logic          initialize;
  logic          initialized;
  logic          error;

  request_slot_queue #(.DATA_WIDTH(DW), .LSIZE(LS)) dut (
    .clk(clk), .resetn(resetn),
    .push_en_in(push_en_in), .push_data_in(push_data_in),
    .push_slot_id_out(push_slot_id_out), .push_done_out(push_done_out),
    .pop_en_in(pop_en_in), .pop_slot_id_in(pop_slot_id_in), .pop_data_out(pop_data_out),
    .initialize(initialize), .initialized(initialized), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model state
  int unsigned free_q[$];
  bit          alloc_m [N];
  bit [DW-1:0] mem_m   [N];
  bit          known_m [N];
  int          init_left;
  bit          ready_m, err_m;

  // Expected outputs after the next edge, and currently visible expectations
  bit          n_done, n_init, n_err, n_pop_known;
  int unsigned n_id;
  bit [DW-1:0] n_pop;
  bit          exp_done, exp_init, exp_err, exp_pop_known;
  int unsigned exp_id;
  bit [DW-1:0] exp_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    for (int i = 0; i < N; i++) alloc_m[i] = 0;
    init_left = 0; ready_m = 0; err_m = 0;
    n_done = 0; n_id = 0; n_pop = '0; n_pop_known = 1; n_init = 0; n_err = 0;
    exp_done = 0; exp_id = 0; exp_pop = '0; exp_pop_known = 1; exp_init = 0; exp_err = 0;
  endtask

  task automatic model_step();
    bit          was_alloc, old_known;
    bit [DW-1:0] old_data;
    int unsigned id;
    n_done = 0;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (initialize) begin
      free_q.delete();
      for (int i = 0; i < N; i++) alloc_m[i] = 0;
      init_left = N; ready_m = 0; err_m = 0;
    end else if (init_left > 0) begin
      if (push_en_in || pop_en_in) err_m = 1;
      free_q.push_back(N - init_left);
      init_left--;
      if (init_left == 0) ready_m = 1;
    end else if (!ready_m) begin
      if (push_en_in || pop_en_in) err_m = 1;
    end else begin
      was_alloc = alloc_m[pop_slot_id_in];
      old_data  = mem_m[pop_slot_id_in];
      old_known = known_m[pop_slot_id_in];
      if (push_en_in) begin
        if (free_q.size() > 0) begin
          id = free_q.pop_front();
          mem_m[id] = push_data_in; known_m[id] = 1; alloc_m[id] = 1;
          n_done = 1; n_id = id;
        end else err_m = 1;
      end
      if (pop_en_in) begin
        n_pop = old_data; n_pop_known = old_known;
        if (was_alloc) begin
          alloc_m[pop_slot_id_in] = 0;
          free_q.push_back(pop_slot_id_in);
        end else err_m = 1;
      end
    end
    n_init = ready_m;
    n_err  = err_m;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    exp_done = n_done; exp_id = n_id; exp_pop = n_pop; exp_pop_known = n_pop_known;
    exp_init = n_init; exp_err = n_err;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("push_done", 32'(push_done_out), 32'(exp_done));
      if (exp_done) chk("push_slot_id", 32'(push_slot_id_out), exp_id);
      if (exp_pop_known) chk("pop_data", 32'(pop_data_out), 32'(exp_pop));
      chk("initialized", 32'(initialized), 32'(exp_init));
      chk("error", 32'(error), 32'(exp_err));
    end
  end

  task automatic do_init();
    int k;
    initialize = 1; step(); initialize = 0;
    k = 0;
    while (!initialized && k < 20) begin step(); k++; end
    chk("init_latency", 32'(k), 32'd8);
    chk("init_error_clear", 32'(error), 32'd0);
  endtask

  task automatic push1(input logic [DW-1:0] d);
    push_en_in = 1; push_data_in = d; step(); push_en_in = 0;
  endtask

  task automatic pop1(input logic [LS-1:0] id);
    pop_en_in = 1; pop_slot_id_in = id; step(); pop_en_in = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fills;
    push_en_in = 0; push_data_in = '0; pop_en_in = 0; pop_slot_id_in = '0; initialize = 0;
    resetn = 0;
    model_reset();
    repeat (2) step();
    resetn = 1;
    chk_en = 1;
    chk("rst_initialized", 32'(initialized), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_push_done", 32'(push_done_out), 32'd0);
    chk("rst_push_id", 32'(push_slot_id_out), 32'd0);
    chk("rst_pop_data", 32'(pop_data_out), 32'd0);

    // Push before any init is flagged
    push1(16'hDEAD);
    chk("idle_push_done", 32'(push_done_out), 32'd0);
    chk("idle_push_err", 32'(error), 32'd1);

    // Init then 8 back-to-back pushes, 9th fails
    do_init();
    for (int i = 0; i < N; i++) begin
      push_en_in = 1; push_data_in = 16'hA000 + 16'(i); step();
      chk("bb_done", 32'(push_done_out), 32'd1);
      chk("bb_id", 32'(push_slot_id_out), 32'(i));
    end
    push_data_in = 16'hA0FF; step(); push_en_in = 0;
    chk("full_push_done", 32'(push_done_out), 32'd0);
    chk("full_push_err", 32'(error), 32'd1);
    step();

    // Push/pop round trip, then ID reuse order
    do_init();
    push1(16'h1234);
    chk("rt_id", 32'(push_slot_id_out), 32'd0);
    pop1(3'd0);
    chk("rt_pop_data", 32'(pop_data_out), 32'h1234);
    chk("rt_err", 32'(error), 32'd0);
    for (int i = 0; i < N; i++) begin
      push1(16'hB000 + 16'(i));
      chk("reuse_id", 32'(push_slot_id_out), 32'((i + 1) % N));
    end

    // Full: push and pop 3 together, push fails; next push gets 3
    push_en_in = 1; push_data_in = 16'hC000; pop_en_in = 1; pop_slot_id_in = 3'd3;
    step(); push_en_in = 0; pop_en_in = 0;
    chk("same_cyc_done", 32'(push_done_out), 32'd0);
    chk("same_cyc_err", 32'(error), 32'd1);
    chk("same_cyc_pop", 32'(pop_data_out), 32'hB002);
    push1(16'hC001);
    chk("after_same_id", 32'(push_slot_id_out), 32'd3);

    // Release order reuse and write-then-read
    pop1(3'd6);
    pop1(3'd2);
    push1(16'hD000);
    chk("rel_id6", 32'(push_slot_id_out), 32'd6);
    push_en_in = 1; push_data_in = 16'hD001; pop_en_in = 1; pop_slot_id_in = 3'd6;
    step(); push_en_in = 0; pop_en_in = 0;
    chk("rel_id2", 32'(push_slot_id_out), 32'd2);
    chk("wtr_data", 32'(pop_data_out), 32'hD000);
    push1(16'hD002);
    chk("rel_id6b", 32'(push_slot_id_out), 32'd6);

    // Pop of an unallocated slot returns data, flags error, frees nothing extra
    do_init();
    pop1(3'd5);
    chk("unalloc_data", 32'(pop_data_out), 32'hB004);
    chk("unalloc_err", 32'(error), 32'd1);
    fills = 0;
    for (int i = 0; i < N + 1; i++) begin
      push1(16'hE000 + 16'(i));
      if (push_done_out) fills++;
    end
    chk("unalloc_fill_count", 32'(fills), 32'd8);

    // Reset in the middle of init, including an illegal push during INIT
    initialize = 1; step(); initialize = 0;
    push1(16'hF000);
    chk("init_push_err", 32'(error), 32'd1);
    step(); step();
    resetn = 0;
    model_reset();
    #1;
    chk("midrst_initialized", 32'(initialized), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_push_done", 32'(push_done_out), 32'd0);
    chk("midrst_push_id", 32'(push_slot_id_out), 32'd0);
    chk("midrst_pop_data", 32'(pop_data_out), 32'd0);
    step();
    resetn = 1;
    step();
    chk("midrst_idle", 32'(initialized), 32'd0);
    do_init();
    push1(16'h5555);
    chk("post_rst_id", 32'(push_slot_id_out), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_slot_queue.md
# request_slot_queue

Slot-addressed request store for the CPU-NIC transmit path. A pushed request is written into a free slot, and the slot ID is returned so the caller can queue it in a per-flow FIFO. Later, the request is read back by slot ID and that slot is freed. Free slots are tracked in an internal free-ID list that is built by an explicit initialization sequence.

## Interface
Parameters:
- DATA_WIDTH, default 64: width of one stored request.
- LSIZE, default 3: log2 of slot count; N = 2**LSIZE slots, slot IDs are LSIZE bits.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- push_en_in  in  1  push request, single-cycle pulse per request.
- push_data_in  in  DATA_WIDTH  request data, sampled with push_en_in.
- push_slot_id_out  out  LSIZE  slot allocated to the push; valid with push_done_out.
- push_done_out  out  1  one-cycle pulse: push accepted.
- pop_en_in  in  1  read-and-free request.
- pop_slot_id_in  in  LSIZE  slot to read and free.
- pop_data_out  out  DATA_WIDTH  data of popped slot; holds until the next pop.
- initialize  in  1  pulse: (re)build the free list.
- initialized  out  1  high once the free list is built; push/pop legal only while high.
- error  out  1  sticky error flag.

## Operation
- State:
  - slot memory of N × DATA_WIDTH;
  - free-ID FIFO of depth N with head, tail and count (LSIZE+1 bits);
  - per-slot allocated bit;
  - init counter.
- Init state machine: IDLE → INIT → READY.
  - A sampled `initialize` pulse in any state enters INIT. On entry: clear all allocated bits, reset head/tail/count to 0, drive `initialized` low, clear `error`.
  - INIT writes slot IDs 0,1,…,N-1 into the free FIFO, one per cycle (N cycles). After the last write, go to READY and set `initialized` high.
- Push (READY, push_en_in=1):
  - Free FIFO non-empty: pop head ID, write data to that slot, set its allocated bit, register `push_slot_id_out`, pulse `push_done_out`.
  - Free FIFO empty: drop the data, no `push_done_out`, set `error`.
- Pop (READY, pop_en_in=1):
  - Register memory[pop_slot_id_in] into `pop_data_out`.
  - If the slot is allocated: clear its bit and append the ID at the free FIFO tail.
  - If the slot is not allocated: the data is still returned, the ID is NOT appended (no duplicate free IDs), and `error` is set.
- Push and pop in the same cycle:
  - Both execute. The push sees the free count before the pop's release, so a push at count 0 fails even if a pop occurs in that cycle.
  - Push and pop of the same slot in one cycle cannot occur, because the push takes only free IDs.
  - Net count is unchanged when both succeed.
- Push or pop while not READY: ignored, sets `error`.
- Allocation order after init is FIFO: the first N pushes receive IDs 0..N-1. Freed IDs are reused in release order.
- `error` clears only on reset or a new `initialize`.

## Timing
- Reset values (asynchronous, while resetn=0):
  - state IDLE, `initialized`=0, `error`=0;
  - `push_done_out`=0, `push_slot_id_out`=0, `pop_data_out`=0;
  - count=0, allocated bits=0.
  - Memory contents are not reset.
- Init latency: `initialize` sampled at edge T → `initialized`=1 after edge T+N (high from cycle T+N+1). Push/pop in between are ignored and flagged.
- Push latency is 1: `push_en_in` sampled at edge T → `push_done_out` and `push_slot_id_out` valid in cycle T+1 only. Back-to-back pushes on every cycle are supported.
- Pop latency is 1: `pop_en_in` sampled at edge T → `pop_data_out` valid from cycle T+1. The freed ID is available to a push sampled at edge T+1 or later.
- Write-then-read: a slot pushed at edge T may be popped at edge T+1 and returns the new data.
- Reset asserted mid-init or mid-operation: everything returns to reset values immediately. An `initialize` is required afterwards.

## Test plan
(DATA_WIDTH=16, LSIZE=3, N=8.)
- Reset, pulse `initialize` → `initialized` rises exactly 8 cycles later, `error`=0.
- 8 back-to-back pushes with data 0xA000..0xA007 → `push_done_out` pulses on 8 consecutive cycles with slot IDs 0..7. A 9th push gives no `push_done_out` and `error`=1.
- After init: push 0x1234 then pop the returned slot 0 → `pop_data_out`=0x1234 one cycle after the pop. The next 8 pushes get IDs 1..7 then 0.
- Fill all 8 slots, then push and pop slot 3 in the same cycle → push fails with `error`=1. A push on the next cycle gets ID 3.
- Pop slot 5 when it was never allocated → data returned, `error`=1. A subsequent full fill yields 7 successful pushes only if slot 5 was otherwise allocated (check count unchanged).
- Assert resetn low mid-init (cycle 4) → `initialized`=0 and outputs at reset values. Re-`initialize` completes normally in 8 cycles.
